multi_channel_clk_divider: RTL

Parametrised successor to the single-channel programmable clock divider. Provides NUM_CH independent divider channels from one clock. Each channel has off, 50% square, single-cycle pulse and programmable-duty PWM modes. Adds a per-channel phase-offset handshake, a global synchronous restart for channel alignment, and a per-channel wrap strobe. Sits on the fast (x2) clock domain and drives trigger and reference outputs.

---
 rtl/multi_channel_clk_divider.sv | 126 ++++++++++++
 1 files changed

// File: rtl/multi_channel_clk_divider.sv
// NUM_CH independent programmable clock dividers (off / square / pulse / PWM)
// with a per-channel phase-offset handshake, global restart and wrap strobes.
module multi_channel_clk_divider #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 30,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*NUM_CH-1:0]     ch_mode,
    input  logic [CNT_W*NUM_CH-1:0] ch_modulus,
    input  logic [CNT_W*NUM_CH-1:0] ch_high_count,
    input  logic                    sync_restart,
    input  logic [CNT_W-1:0]        phase_value,
    input  logic [SEL_W-1:0]        phase_ch_sel,
    input  logic                    phase_valid,
    output logic                    phase_ready,
    output logic [NUM_CH-1:0]       data_output,
    output logic [NUM_CH-1:0]       wrap_strobe
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] take;

    // An out-of-range selector never matches a channel, so it is never ready.
    always_comb begin
        phase_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (phase_ch_sel == SEL_W'(k)) begin
                phase_ready = !pend[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [1:0]       mode;
        logic [CNT_W-1:0] modulus;
        logic [CNT_W-1:0] high_count;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic [CNT_W-1:0] pval;
        logic [CNT_W-1:0] pval_n;
        logic             tog;
        logic             tog_n;
        logic             pend_q;
        logic             pend_n;
        logic             reload;
        logic             out_n;
        logic             out_q;
        logic             reload_q;
        logic             dout_q;
        logic             wrap_q;

        assign mode        = ch_mode[2*k +: 2];
        assign modulus     = ch_modulus[CNT_W*k +: CNT_W];
        assign high_count  = ch_high_count[CNT_W*k +: CNT_W];
        assign take[k]     = phase_valid && phase_ready && (phase_ch_sel == SEL_W'(k));
        assign pend[k]     = pend_q;
        assign data_output[k] = dout_q;
        assign wrap_strobe[k] = wrap_q;

        // A transfer coinciding with a reload is stored after the reload consumes the old offset.
        always_comb begin
            cnt_n  = cnt;
            tog_n  = tog;
            pend_n = pend_q;
            pval_n = pval;
            reload = 1'b0;
            out_n  = 1'b0;
            if (mode == 2'b00) begin
                cnt_n  = '0;
                tog_n  = 1'b0;
                pend_n = 1'b0;
            end else begin
                if (sync_restart) begin
                    cnt_n = '0;
                    tog_n = 1'b0;
                end else if (cnt < modulus) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    reload = 1'b1;
                    cnt_n  = pend_q ? pval : '0;
                    pend_n = 1'b0;
                end
                if (take[k]) begin
                    pend_n = 1'b1;
                    pval_n = phase_value;
                end
                if (mode == 2'b01 && reload) begin
                    tog_n = ~tog;
                end
                if (!sync_restart) begin
                    case (mode)
                        2'b01:   out_n = tog_n;
                        2'b10:   out_n = reload;
                        2'b11:   out_n = (cnt_n < high_count);
                        default: out_n = 1'b0;
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt      <= '0;
                tog      <= 1'b0;
                pend_q   <= 1'b0;
                pval     <= '0;
                out_q    <= 1'b0;
                reload_q <= 1'b0;
                dout_q   <= 1'b0;
                wrap_q   <= 1'b0;
            end else begin
                cnt      <= cnt_n;
                tog      <= tog_n;
                pend_q   <= pend_n;
                pval     <= pval_n;
                out_q    <= out_n;
                reload_q <= reload;
                dout_q   <= out_q;
                wrap_q   <= reload_q;
            end
        end
    end

endmodule
